// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared opcodes, widths and FSM state type for the SPI master
package spi_pkg;
    localparam int CMD_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CHK,
        ST_SHIFT,
        ST_TURN,
        ST_CAPTURE,
        ST_DONE,
        ST_GAP_W
    } state_e;
endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parallel-load shift register, MSB-first out, serial-in at the LSB
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] par_o
);
    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], ser_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_o = sr_q;
endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: serialises 10-bit commands, captures read-data replies
// Optional read-sequence checking with cmd_err: SPI_MASTER_SEQ_CHECK_EN
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int TURNAROUND = 3,
    parameter int GAP        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SS_n,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    output logic              cmd_err
`endif
);
    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [CMD_W-1:0]   tx_par;
    logic [DATA_W-1:0]  rx_par;
    logic               accept;
    logic               reject;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_addr_seen_q, rd_addr_seen_d;
    logic cmd_err_q;

    assign reject = (cmd_data[CMD_W-1 -: 2] == OP_RD_DATA) && !rd_addr_seen_q;

    always_comb begin
        rd_addr_seen_d = rd_addr_seen_q;
        if (accept && cmd_data[CMD_W-1 -: 2] == OP_RD_ADDR) begin
            rd_addr_seen_d = 1'b1;
        end else if (state_q == ST_DONE) begin
            rd_addr_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_seen_q <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            rd_addr_seen_q <= rd_addr_seen_d;
            cmd_err_q      <= accept && reject;
        end
    end

    assign cmd_err = cmd_err_q;
`else
    assign reject = 1'b0;
`endif

    spi_shift_reg #(.W(CMD_W)) u_tx_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (cmd_data),
        .shift_i     (state_q == ST_SHIFT),
        .ser_i       (1'b0),
        .par_o       (tx_par)
    );

    // Capture register is cleared on accept so a stale reply never leaks into a new frame.
    spi_shift_reg #(.W(DATA_W)) u_rx_sr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (state_q == ST_CAPTURE),
        .ser_i       (MISO),
        .par_o       (rx_par)
    );

    logic unused_tx_low;
    assign unused_tx_low = ^tx_par[CMD_W-2:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = cmd_data[CMD_W-1 -: 2];
                    cnt_d   = reject ? GAP_LAST : 4'd0;
                    state_d = reject ? ST_GAP_W : ST_SELECT;
                end
            end
            ST_SELECT: state_d = ST_CHK;
            ST_CHK: begin
                cnt_d   = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == 4'(CMD_W - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = (op_q == OP_RD_DATA) ? ST_TURN : ST_GAP_W;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                if (cnt_q == 4'(DATA_W - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // DONE already counts as the first high cycle of the gap.
                rd_data_d = rx_par;
                if (GAP_LAST == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = 4'd1;
                    state_d = ST_GAP_W;
                end
            end
            ST_GAP_W: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_q      <= 2'b00;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign SS_n     = !(state_q inside {ST_SELECT, ST_CHK, ST_SHIFT, ST_TURN, ST_CAPTURE});
    assign MOSI     = (state_q == ST_CHK || state_q == ST_SHIFT) ? tx_par[CMD_W-1] : 1'b0;
    assign rd_valid = (state_q == ST_DONE);
    assign rd_data  = (state_q == ST_DONE) ? rx_par : rd_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_data = '0;
    logic       MISO, MOSI, SS_n, rd_valid, busy;
    logic [7:0] rd_data;
    logic       slave_en = 1'b0, slave_miso = 1'b0, miso_drv = 1'b0;
    int         tests_run = 0, tests_failed = 0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic       cmd_err;
`endif

    assign MISO = slave_en ? slave_miso : miso_drv;
    always #5 clk = ~clk;

    spi_master_ctrl #(.TURNAROUND(3), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .MISO(MISO), .MOSI(MOSI), .SS_n(SS_n),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
`ifdef SPI_MASTER_SEQ_CHECK_EN
        , .cmd_err(cmd_err)
`endif
    );

    // Behavioural RAM slave: decodes bits from low cycles 3..12, replies in low cycles 16..23.
    logic [7:0] smem [256];
    logic [7:0] s_addr = '0, s_raddr = '0, s_byte;
    logic [9:0] s_sreg = '0;
    int         lcnt = 0;
    initial for (int i = 0; i < 256; i++) smem[i] = 8'h00;

    always @(negedge clk) begin
        if (SS_n) begin
            lcnt = 0;
            slave_miso = 1'b0;
        end else begin
            lcnt++;
            if (lcnt >= 3 && lcnt <= 12) s_sreg = {s_sreg[8:0], MOSI};
            if (lcnt == 12) begin
                case (s_sreg[9:8])
                    OP_WR_ADDR: s_addr = s_sreg[7:0];
                    OP_WR_DATA: smem[s_addr] = s_sreg[7:0];
                    OP_RD_ADDR: s_raddr = s_sreg[7:0];
                    default: ;
                endcase
            end
            s_byte = smem[s_raddr];
            slave_miso = (lcnt >= 16 && lcnt <= 23) ? s_byte[23-lcnt] : 1'b0;
        end
    end

    task automatic issue(input logic [9:0] c);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL issue_timeout cmd=%h: cmd_ready=%b required 1", c, cmd_ready); end
        cmd_data = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run += 6;
        if (SS_n !== 1'b1) begin tests_failed++; $display("FAIL reset_ss_n: got %b required 1", SS_n); end
        if (MOSI !== 1'b0) begin tests_failed++; $display("FAIL reset_mosi: got %b required 0", MOSI); end
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
        if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data: got %h required 00", rd_data); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
`ifdef SPI_MASTER_SEQ_CHECK_EN
        tests_run++;
        if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_err: got %b required 0", cmd_err); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_write_frame;
        logic [11:0] exp_mosi;
        exp_mosi = 12'b0000_1010_0101;
        issue(10'h0A5);
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 12) begin
                tests_run += 2;
                if (SS_n !== 1'b0) begin tests_failed++; $display("FAIL wr_ss_n c%0d: got %b required 0", k, SS_n); end
                if (MOSI !== exp_mosi[12-k]) begin tests_failed++; $display("FAIL wr_mosi c%0d: got %b required %b", k, MOSI, exp_mosi[12-k]); end
            end else if (k == 13) begin
                tests_run += 3;
                if (SS_n !== 1'b1) begin tests_failed++; $display("FAIL wr_gap_ss_n: got %b required 1", SS_n); end
                if (MOSI !== 1'b0) begin tests_failed++; $display("FAIL wr_gap_mosi: got %b required 0", MOSI); end
                if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL wr_gap_ready: got %b required 0", cmd_ready); end
            end else begin
                tests_run += 2;
                if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_idle_ready: got %b required 1", cmd_ready); end
                if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_idle_busy: got %b required 0", busy); end
            end
        end
    endtask

    task automatic test_slave_sequence;
        logic       got = 1'b0;
        logic [7:0] data = 8'h00;
        slave_en = 1'b1;
        issue(10'h010);
        issue(10'h13C);
        issue(10'h210);
        issue(10'h300);
        for (int n = 0; n < 40; n++) begin
            if (rd_valid === 1'b1) begin got = 1'b1; data = rd_data; break; end
            @(negedge clk);
        end
        tests_run += 2;
        if (got !== 1'b1) begin tests_failed++; $display("FAIL slave_rd_valid_timeout: got %b required 1", got); end
        if (data !== 8'h3C) begin tests_failed++; $display("FAIL slave_rd_data: got %h required 3c", data); end
        @(negedge clk);
        slave_en = 1'b0;
    endtask

    task automatic test_read_capture;
        logic [7:0] pat;
        pat = 8'hB2;
        issue(10'h200);
        issue(10'h300);
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) @(negedge clk);
            tests_run++;
            if (k < 24) begin
                if ({rd_valid, rd_data} !== {1'b0, 8'h3C}) begin tests_failed++; $display("FAIL rd_early c%0d: got valid=%b data=%h required valid=0 data=3c", k, rd_valid, rd_data); end
            end else if (k == 24) begin
                if ({rd_valid, rd_data, SS_n} !== {1'b1, 8'hB2, 1'b1}) begin tests_failed++; $display("FAIL rd_done: got valid=%b data=%h ss_n=%b required valid=1 data=b2 ss_n=1", rd_valid, rd_data, SS_n); end
            end else begin
                if ({rd_valid, rd_data, cmd_ready} !== {1'b0, 8'hB2, 1'b1}) begin tests_failed++; $display("FAIL rd_after: got valid=%b data=%h ready=%b required valid=0 data=b2 ready=1", rd_valid, rd_data, cmd_ready); end
            end
            if (k == 23) begin
                tests_run++;
                if (SS_n !== 1'b0) begin tests_failed++; $display("FAIL rd_capture_ss_n: got %b required 0", SS_n); end
            end
            miso_drv = (k >= 16 && k <= 23) ? pat[23-k] : 1'b1;
        end
        miso_drv = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0] cmds [3];
        int   idx = 0, frames = 0, idle_gap = 0, gap_hi = 0, low_cycles = 0, bad = 0, n = 0;
        logic prev_ss = 1'b1, pend;
        cmds = '{10'h011, 10'h122, 10'h033};
        @(negedge clk);
        while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
        cmd_data = cmds[0];
        cmd_valid = 1'b1;
        pend = cmd_ready;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (pend) begin
                idx++;
                if (idx == 3) cmd_valid = 1'b0; else cmd_data = cmds[idx];
            end
            if (prev_ss && !SS_n) frames++;
            if (!SS_n) low_cycles++;
            if (frames inside {1, 2} && !busy) idle_gap++;
            if (frames inside {1, 2} && busy && SS_n) gap_hi++;
            if (!SS_n && !busy) bad++;
            prev_ss = SS_n;
            pend = cmd_ready && cmd_valid;
        end
        cmd_valid = 1'b0;
        tests_run += 6;
        if (frames != 3) begin tests_failed++; $display("FAIL b2b_frames: got %0d required 3", frames); end
        if (idx != 3) begin tests_failed++; $display("FAIL b2b_accepts: got %0d required 3", idx); end
        if (low_cycles != 36) begin tests_failed++; $display("FAIL b2b_low_cycles: got %0d required 36", low_cycles); end
        if (gap_hi != 2) begin tests_failed++; $display("FAIL b2b_gap_cycles: got %0d required 2", gap_hi); end
        if (idle_gap != 2) begin tests_failed++; $display("FAIL b2b_idle_cycles: got %0d required 2", idle_gap); end
        if (bad != 0) begin tests_failed++; $display("FAIL b2b_busy_low_in_frame: got %0d required 0", bad); end
    endtask

    task automatic test_reset_midframe;
        int         rv = 0, low = 0;
        logic [9:0] sh = '0;
        issue(10'h200);
        issue(10'h300);
        repeat (6) @(negedge clk);
        tests_run++;
        if (SS_n !== 1'b0) begin tests_failed++; $display("FAIL mid_ss_before: got %b required 0", SS_n); end
        rst_n = 1'b0;
        #1;
        tests_run += 3;
        if (SS_n !== 1'b1) begin tests_failed++; $display("FAIL mid_ss_async: got %b required 1", SS_n); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b required 0", busy); end
        if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL mid_rd_data: got %h required 00", rd_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (rd_valid) rv++; end
        tests_run++;
        if (rv != 0) begin tests_failed++; $display("FAIL mid_rd_valid_pulses: got %0d required 0", rv); end
        issue(10'h15A);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            if (!SS_n) low++;
            if (k >= 3 && k <= 12) sh = {sh[8:0], MOSI};
        end
        tests_run += 2;
        if (low != 12) begin tests_failed++; $display("FAIL mid_next_low: got %0d required 12", low); end
        if (sh !== 10'h15A) begin tests_failed++; $display("FAIL mid_next_bits: got %h required 15a", sh); end
    endtask

`ifdef SPI_MASTER_SEQ_CHECK_EN
    task automatic test_seq_check;
        int errs = 0, lows = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(10'h300);
        tests_run += 2;
        if (cmd_err !== 1'b1) begin tests_failed++; $display("FAIL seq_err_pulse: got %b required 1", cmd_err); end
        if (SS_n !== 1'b1) begin tests_failed++; $display("FAIL seq_err_ss_n: got %b required 1", SS_n); end
        @(negedge clk);
        tests_run += 2;
        if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL seq_err_clear: got %b required 0", cmd_err); end
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL seq_err_ready: got %b required 1", cmd_ready); end
        issue(10'h210);
        issue(10'h300);
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) @(negedge clk);
            if (cmd_err) errs++;
            if (!SS_n) lows++;
        end
        tests_run += 2;
        if (errs != 0) begin tests_failed++; $display("FAIL seq_ok_err: got %0d required 0", errs); end
        if (lows != 23) begin tests_failed++; $display("FAIL seq_ok_low: got %0d required 23", lows); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_frame();
        test_slave_sequence();
        test_read_capture();
        test_back_to_back();
        test_reset_midframe();
`ifdef SPI_MASTER_SEQ_CHECK_EN
        test_seq_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
